// File: rtl/serial_link_phy_cfg_ctrl.sv
// Run-time reconfiguration sequencer for the serial-link PHY TX clock divider/phase shifter.
// Drains an in-flight beat, gates TX valid while new values are applied, then holds a settle window.
module serial_link_phy_cfg_ctrl #(
   parameter int unsigned MaxClkDiv     = 32,
   parameter bit          DdrSdrSel     = 1'b1,
   parameter int unsigned ResetClkDiv   = 8,
   parameter int unsigned ResetShiftSt  = 2,
   parameter int unsigned ResetShiftEnd = 6,
   parameter int unsigned SettleCycles  = 4,
   localparam int         CW            = $clog2(MaxClkDiv) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cfg_req_i,
   input  logic [CW-1:0] cfg_clk_div_i,
   input  logic [CW-1:0] cfg_shift_start_i,
   input  logic [CW-1:0] cfg_shift_end_i,
   output logic          cfg_gnt_o,
   output logic          cfg_err_o,
   output logic          cfg_busy_o,
   input  logic          tx_valid_i,
   output logic          tx_ready_o,
   output logic          phy_valid_o,
   input  logic          phy_ready_i,
   output logic [CW-1:0] phy_clk_div_o,
   output logic [CW-1:0] phy_shift_start_o,
   output logic [CW-1:0] phy_shift_end_o,
   output logic [1:0]    dbg_state_o
);

   localparam int CNTW = $clog2(SettleCycles) + 1;
   localparam logic [CNTW-1:0] SettleLoad = CNTW'(SettleCycles - 1);
   localparam logic [CW:0]     MaxDivX    = (CW+1)'(MaxClkDiv);
   localparam logic [CW:0]     MinDivX    = (CW+1)'(2);
   localparam logic [CW-1:0]   RstDiv     = CW'(ResetClkDiv);
   localparam logic [CW-1:0]   RstStart   = CW'(ResetShiftSt);
   localparam logic [CW-1:0]   RstEnd     = CW'(ResetShiftEnd);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_APPLY  = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   state_t          r_state;
   logic [CNTW-1:0] r_cnt;
   logic [CW-1:0]   r_sh_div;
   logic [CW-1:0]   r_sh_start;
   logic [CW-1:0]   r_sh_end;
   logic [CW-1:0]   r_div;
   logic [CW-1:0]   r_start;
   logic [CW-1:0]   r_end;
   logic            r_gnt;
   logic            r_err;

   // Legality is evaluated one bit wider so the DDR period 2*div cannot wrap.
   logic [CW:0] w_div_x;
   logic [CW:0] w_period;
   logic        w_legal;
   logic        w_fwd;

   assign w_div_x  = {1'b0, cfg_clk_div_i};
   assign w_period = DdrSdrSel ? {cfg_clk_div_i, 1'b0} : w_div_x;
   assign w_legal  = (w_div_x >= MinDivX) && (w_div_x <= MaxDivX) && !cfg_clk_div_i[0] &&
                     (cfg_shift_start_i < cfg_shift_end_i) &&
                     ({1'b0, cfg_shift_end_i} < w_period);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_RUN;
         r_cnt      <= '0;
         r_sh_div   <= '0;
         r_sh_start <= '0;
         r_sh_end   <= '0;
         r_div      <= RstDiv;
         r_start    <= RstStart;
         r_end      <= RstEnd;
         r_gnt      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_gnt <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (cfg_req_i) begin
                  if (w_legal) begin
                     r_sh_div   <= cfg_clk_div_i;
                     r_sh_start <= cfg_shift_start_i;
                     r_sh_end   <= cfg_shift_end_i;
                     r_state    <= (tx_valid_i && !phy_ready_i) ? ST_DRAIN : ST_APPLY;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            // Leave once the pending beat is accepted or withdrawn.
            ST_DRAIN: begin
               if (!tx_valid_i || phy_ready_i) r_state <= ST_APPLY;
            end
            ST_APPLY: begin
               r_div   <= r_sh_div;
               r_start <= r_sh_start;
               r_end   <= r_sh_end;
               r_cnt   <= SettleLoad;
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= ST_RUN;
                  r_gnt   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign w_fwd             = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign phy_valid_o       = w_fwd & tx_valid_i;
   assign tx_ready_o        = w_fwd & tx_valid_i & phy_ready_i;
   assign cfg_busy_o        = (r_state != ST_RUN);
   assign cfg_gnt_o         = r_gnt;
   assign cfg_err_o         = r_err;
   assign phy_clk_div_o     = r_div;
   assign phy_shift_start_o = r_start;
   assign phy_shift_end_o   = r_end;
   assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_serial_link_phy_cfg_ctrl.sv
// Directed bench for serial_link_phy_cfg_ctrl (DDR, MaxClkDiv=32, SettleCycles=4).
module tb_serial_link_phy_cfg_ctrl;

   localparam int CW = 6;
   localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_APPLY = 2'd2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_req = 1'b0;
   logic [CW-1:0] cfg_div = '0, cfg_start = '0, cfg_end = '0;
   logic          gnt, err, busy;
   logic          tx_valid = 1'b0, tx_ready, phy_valid, phy_ready = 1'b0;
   logic [CW-1:0] o_div, o_start, o_end;
   logic [1:0]    dbg_state;

   int vec_cnt = 0;
   int err_cnt = 0;

   serial_link_phy_cfg_ctrl dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_req_i(cfg_req), .cfg_clk_div_i(cfg_div),
      .cfg_shift_start_i(cfg_start), .cfg_shift_end_i(cfg_end),
      .cfg_gnt_o(gnt), .cfg_err_o(err), .cfg_busy_o(busy),
      .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
      .phy_valid_o(phy_valid), .phy_ready_i(phy_ready),
      .phy_clk_div_o(o_div), .phy_shift_start_o(o_start), .phy_shift_end_o(o_end),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [CW-1:0] d, input logic [CW-1:0] s, input logic [CW-1:0] e);
      cfg_req   = 1'b1;
      cfg_div   = d;
      cfg_start = s;
      cfg_end   = e;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      vec_cnt++;
      if ({o_div, o_start, o_end} !== {6'd8, 6'd2, 6'd6}) begin
         err_cnt++; $display("FAIL reset_cfg: got %0d/%0d/%0d expected 8/2/6", o_div, o_start, o_end);
      end
      vec_cnt++;
      if ({busy, gnt, err} !== 3'b000) begin
         err_cnt++; $display("FAIL reset_flags: got busy/gnt/err=%b expected 000", {busy, gnt, err});
      end
      vec_cnt++;
      if (dbg_state !== S_RUN) begin
         err_cnt++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_RUN);
      end
   endtask

   task automatic test_cfg_apply();
      set_req(6'd4, 6'd1, 6'd5);
      #1;
      vec_cnt++;
      if (busy !== 1'b0) begin
         err_cnt++; $display("FAIL apply_req_busy: got %b expected 0", busy);
      end
      tick();
      cfg_req   = 1'b0;
      tx_valid  = 1'b1;
      phy_ready = 1'b1;
      #1;
      vec_cnt++;
      if (dbg_state !== S_APPLY) begin
         err_cnt++; $display("FAIL apply_state: got %0d expected %0d", dbg_state, S_APPLY);
      end
      vec_cnt++;
      if ({o_div, o_start, o_end} !== {6'd8, 6'd2, 6'd6}) begin
         err_cnt++; $display("FAIL apply_cfg_early: got %0d/%0d/%0d expected 8/2/6", o_div, o_start, o_end);
      end
      vec_cnt++;
      if ({phy_valid, tx_ready} !== 2'b00) begin
         err_cnt++; $display("FAIL apply_gate: got valid/ready=%b expected 00", {phy_valid, tx_ready});
      end
      for (int k = 2; k <= 7; k++) begin
         tick();
         if (k == 2) begin
            vec_cnt++;
            if ({o_div, o_start, o_end} !== {6'd4, 6'd1, 6'd5}) begin
               err_cnt++; $display("FAIL apply_cfg: got %0d/%0d/%0d expected 4/1/5", o_div, o_start, o_end);
            end
         end
         vec_cnt++;
         if (gnt !== logic'(k == 6)) begin
            err_cnt++; $display("FAIL apply_gnt_k%0d: got %b expected %b", k, gnt, k == 6);
         end
         vec_cnt++;
         if (phy_valid !== logic'(k >= 6)) begin
            err_cnt++; $display("FAIL apply_valid_k%0d: got %b expected %b", k, phy_valid, k >= 6);
         end
         vec_cnt++;
         if (busy !== logic'(k <= 5)) begin
            err_cnt++; $display("FAIL apply_busy_k%0d: got %b expected %b", k, busy, k <= 5);
         end
      end
      tx_valid  = 1'b0;
      phy_ready = 1'b0;
   endtask

   task automatic test_drain();
      tx_valid  = 1'b1;
      phy_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vec_cnt++;
         if ({phy_valid, tx_ready} !== 2'b10) begin
            err_cnt++; $display("FAIL drain_stall%0d: got valid/ready=%b expected 10", i, {phy_valid, tx_ready});
         end
      end
      set_req(6'd16, 6'd3, 6'd20);
      tick();
      cfg_req = 1'b0;
      vec_cnt++;
      if (dbg_state !== S_DRAIN) begin
         err_cnt++; $display("FAIL drain_enter: got %0d expected %0d", dbg_state, S_DRAIN);
      end
      tick();
      vec_cnt++;
      if ({dbg_state, phy_valid} !== {S_DRAIN, 1'b1}) begin
         err_cnt++; $display("FAIL drain_hold: got state/valid=%0d/%b expected 1/1", dbg_state, phy_valid);
      end
      phy_ready = 1'b1;
      #1;
      vec_cnt++;
      if (tx_ready !== 1'b1) begin
         err_cnt++; $display("FAIL drain_beat: got tx_ready=%b expected 1", tx_ready);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k <= 2) begin
            vec_cnt++;
            if (o_div !== ((k == 1) ? 6'd4 : 6'd16)) begin
               err_cnt++; $display("FAIL drain_div_k%0d: got %0d expected %0d", k, o_div, (k == 1) ? 4 : 16);
            end
         end
         vec_cnt++;
         if ({phy_valid, gnt} !== {logic'(k == 6), logic'(k == 6)}) begin
            err_cnt++; $display("FAIL drain_gate_k%0d: got valid/gnt=%b expected %b", k, {phy_valid, gnt}, {k == 6, k == 6});
         end
      end
      vec_cnt++;
      if ({o_start, o_end} !== {6'd3, 6'd20}) begin
         err_cnt++; $display("FAIL drain_shift: got %0d/%0d expected 3/20", o_start, o_end);
      end
      tx_valid  = 1'b0;
      phy_ready = 1'b0;
   endtask

   task automatic test_illegal();
      logic [3*CW-1:0] vecs [4];
      vecs[0] = {6'd3,  6'd1, 6'd2};
      vecs[1] = {6'd34, 6'd1, 6'd2};
      vecs[2] = {6'd8,  6'd5, 6'd5};
      vecs[3] = {6'd4,  6'd1, 6'd8};
      for (int i = 0; i < 4; i++) begin
         set_req(vecs[i][17:12], vecs[i][11:6], vecs[i][5:0]);
         tick();
         cfg_req = 1'b0;
         vec_cnt++;
         if ({err, busy, dbg_state} !== {1'b1, 1'b0, S_RUN}) begin
            err_cnt++; $display("FAIL illegal%0d_err: got err/busy/state=%b/%b/%0d expected 1/0/0", i, err, busy, dbg_state);
         end
         tick();
         vec_cnt++;
         if ({err, o_div, o_start, o_end} !== {1'b0, 6'd16, 6'd3, 6'd20}) begin
            err_cnt++; $display("FAIL illegal%0d_hold: got err=%b cfg=%0d/%0d/%0d expected 0 16/3/20", i, err, o_div, o_start, o_end);
         end
      end
   endtask

   task automatic test_settle_req();
      int gnts = 0;
      int errs = 0;
      set_req(6'd8, 6'd2, 6'd6);
      tick();
      cfg_req = 1'b0;
      tick();
      set_req(6'd6, 6'd1, 6'd3);
      tick();
      cfg_req = 1'b0;
      vec_cnt++;
      if ({busy, o_div, o_start, o_end} !== {1'b1, 6'd8, 6'd2, 6'd6}) begin
         err_cnt++; $display("FAIL settle_req_cfg: got busy=%b cfg=%0d/%0d/%0d expected 1 8/2/6", busy, o_div, o_start, o_end);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         gnts += int'(gnt);
         errs += int'(err);
      end
      vec_cnt++;
      if ({gnts, errs} !== {32'd1, 32'd0}) begin
         err_cnt++; $display("FAIL settle_req_pulses: got gnt=%0d err=%0d expected 1/0", gnts, errs);
      end
      vec_cnt++;
      if ({dbg_state, o_div, o_start, o_end} !== {S_RUN, 6'd8, 6'd2, 6'd6}) begin
         err_cnt++; $display("FAIL settle_req_final: got state=%0d cfg=%0d/%0d/%0d expected 0 8/2/6", dbg_state, o_div, o_start, o_end);
      end
   endtask

   task automatic test_boundary();
      int gnts = 0;
      set_req(6'd32, 6'd0, 6'd63);
      tick();
      cfg_req = 1'b0;
      vec_cnt++;
      if ({err, dbg_state} !== {1'b0, S_APPLY}) begin
         err_cnt++; $display("FAIL boundary_accept: got err/state=%b/%0d expected 0/2", err, dbg_state);
      end
      for (int i = 0; i < 7; i++) begin
         tick();
         gnts += int'(gnt);
      end
      vec_cnt++;
      if ({gnts, o_div, o_start, o_end} !== {32'd1, 6'd32, 6'd0, 6'd63}) begin
         err_cnt++; $display("FAIL boundary_cfg: got gnt=%0d cfg=%0d/%0d/%0d expected 1 32/0/63", gnts, o_div, o_start, o_end);
      end
   endtask

   task automatic test_reset_drain();
      int gnts = 0;
      int busys = 0;
      tx_valid  = 1'b1;
      phy_ready = 1'b0;
      set_req(6'd4, 6'd1, 6'd5);
      tick();
      cfg_req = 1'b0;
      vec_cnt++;
      if (dbg_state !== S_DRAIN) begin
         err_cnt++; $display("FAIL rstdrain_enter: got %0d expected %0d", dbg_state, S_DRAIN);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vec_cnt++;
      if ({busy, gnt, o_div, o_start, o_end} !== {1'b0, 1'b0, 6'd8, 6'd2, 6'd6}) begin
         err_cnt++; $display("FAIL rstdrain_state: got busy=%b gnt=%b cfg=%0d/%0d/%0d expected 0 0 8/2/6", busy, gnt, o_div, o_start, o_end);
      end
      phy_ready = 1'b1;
      #1;
      vec_cnt++;
      if ({phy_valid, tx_ready} !== 2'b11) begin
         err_cnt++; $display("FAIL rstdrain_hs: got valid/ready=%b expected 11", {phy_valid, tx_ready});
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         gnts  += int'(gnt);
         busys += int'(busy);
      end
      vec_cnt++;
      if ({gnts, busys} !== {32'd0, 32'd0}) begin
         err_cnt++; $display("FAIL rstdrain_nognt: got gnt=%0d busy=%0d expected 0/0", gnts, busys);
      end
      tx_valid  = 1'b0;
      phy_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cfg_apply();
      test_drain();
      test_illegal();
      test_settle_req();
      test_boundary();
      test_reset_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
